// File: rtl/wishbone_pkg.sv
// Shared Wishbone types and constants for the controller-sharing arbiter.
package wishbone_pkg;

   localparam int WB_ADR_W = 4;
   localparam int WB_DAT_W = 8;

   // Read data handed back when a transaction is abandoned by the timeout.
   localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DATA = 8'hEE;

   // Controller-side request: strobe, direction, address, write data.
   typedef struct packed {
      logic                stb;
      logic                we;
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
   } iWishbone_Ctrl;

   // Peripheral-side response: acknowledge and read data.
   typedef struct packed {
      logic                ack;
      logic [WB_DAT_W-1:0] dat;
   } iWishbone_Peri;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } eWishboneArbiterState;

endpackage

// File: rtl/wishbone_rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping at N-1 -> 0. Purely combinational.
module wishbone_rr_pick #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] rot;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;

   // Rotate the request vector so ptr lands on bit 0, take the lowest set bit,
   // then map the offset back to an absolute index with an explicit wrap.
   always_comb begin
      rot   = {req, req} >> ptr;
      valid = 1'b0;
      off   = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (rot[k]) begin
            valid = 1'b1;
            off   = IW'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone peripheral port between N
// controllers. Grant is held for a whole transaction; a stuck peripheral is
// released by a synthetic ack after TIMEOUT strobe cycles.
module wishbone_arbiter
   import wishbone_pkg::*;
#(
   parameter int                   N            = 2,
   parameter int                   TIMEOUT      = 255,
   parameter logic [WB_DAT_W-1:0]  TIMEOUT_DATA = WB_TIMEOUT_DATA
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  iWishbone_Ctrl [N-1:0] wb_req,
   output iWishbone_Peri [N-1:0] wb_rsp,
   output iWishbone_Ctrl         wb_c,
   input  iWishbone_Peri         wb_p,
   output logic [N-1:0]          grant,
   output logic                  busy,
   output logic                  timeout_stb
);

   localparam int IW = $clog2(N);
   // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   eWishboneArbiterState state;
   logic [IW-1:0] rr_ptr, grant_idx, pick_idx, next_ptr;
   logic [CW-1:0] cnt;
   logic [N-1:0]  req_stb;
   logic          pick_valid, owner_stb, tmo_fire, done;
   iWishbone_Ctrl owner;

   // Collect the strobes for the picker.
   always_comb begin
      req_stb = '0;
      for (int i = 0; i < N; i++) req_stb[i] = wb_req[i].stb;
   end

   wishbone_rr_pick #(.N(N)) u_pick (
      .req   (req_stb),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign owner     = wb_req[grant_idx];
   assign owner_stb = (state == BUSY) && owner.stb;
   // A real ack in the same cycle always beats the timeout.
   assign tmo_fire  = (TIMEOUT != 0) && owner_stb && !wb_p.ack && (cnt == CNT_LAST);
   // Transaction ends on ack, timeout, or the owner abandoning its strobe.
   assign done      = (state == BUSY) && (wb_p.ack || tmo_fire || !owner.stb);
   assign next_ptr  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

   assign busy  = (state == BUSY);
   assign grant = (state == BUSY) ? (N'(1) << grant_idx) : '0;

   // Forward the owner's request; strobe is suppressed on the timeout cycle.
   always_comb begin
      wb_c     = (state == BUSY) ? owner : '0;
      wb_c.stb = owner_stb && !tmo_fire;
   end

   // Route the ack (real or synthetic) to the owner only; everyone else sees 0.
   always_comb begin
      wb_rsp = '0;
      if ((state == BUSY) && (wb_p.ack || tmo_fire)) begin
         wb_rsp[grant_idx].ack = 1'b1;
         wb_rsp[grant_idx].dat = wb_p.ack ? wb_p.dat : TIMEOUT_DATA;
      end
   end

   // Arbitration FSM: pick in IDLE, hold grant and count strobe cycles in BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_idx   <= '0;
         cnt         <= '0;
         timeout_stb <= 1'b0;
      end else begin
         timeout_stb <= tmo_fire;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_idx <= pick_idx;
                  cnt       <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter (N=2, TIMEOUT=8) with a transaction-level
// reference model checked every cycle, plus a unit check of the picker at N=3.
module tb_wishbone_arbiter;
   import wishbone_pkg::*;

   localparam int N   = 2;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   iWishbone_Ctrl [N-1:0] wb_req;
   iWishbone_Peri [N-1:0] wb_rsp;
   iWishbone_Ctrl         wb_c;
   iWishbone_Peri         wb_p;
   logic [N-1:0]          grant;
   logic                  busy, timeout_stb;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int ack_delay = -1, peri_cnt = 0;
   logic force_ack = 1'b0;
   logic [7:0] peri_dat = 8'h00;
   int rem [N];
   int ack_idx[$], ack_cyc[$], stb_cyc[$];
   logic [7:0] ack_wdat[$], ack_rdat[$];
   logic ack_cstb[$];
   logic prev_stb = 1'b0;

   logic [2:0] pk_req;
   logic [1:0] pk_ptr, pk_idx;
   logic       pk_valid;

   wishbone_arbiter #(.N(N), .TIMEOUT(TMO), .TIMEOUT_DATA(8'hEE)) dut (
      .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_rsp(wb_rsp), .wb_c(wb_c),
      .wb_p(wb_p), .grant(grant), .busy(busy), .timeout_stb(timeout_stb));

   wishbone_rr_pick #(.N(3)) u_pick (
      .req(pk_req), .ptr(pk_ptr), .valid(pk_valid), .idx(pk_idx));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral responder: acks ack_delay cycles into a grant (never if < 0).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)     peri_cnt <= 0;
      else if (!busy) peri_cnt <= 0;
      else            peri_cnt <= peri_cnt + 1;
   end

   always_comb begin
      wb_p.ack = force_ack || (busy && (ack_delay >= 0) && (peri_cnt == ack_delay));
      wb_p.dat = peri_dat;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: owner (-1 = none), round-robin pointer, cycles held.
   int m_owner = -1, m_ptr = 0, m_age = 0;
   logic m_tmo = 1'b0;
   int n_owner = -1, n_ptr = 0, n_age = 0;
   logic n_tmo = 1'b0;

   // Compare DUT outputs mid-cycle against the model and plan the next state.
   always @(negedge clk) begin
      iWishbone_Ctrl o;
      logic ostb, tmo, rack;
      logic [N-1:0] eg;
      int best, bd, d;
      if (rst_n) begin
         o = '0; eg = '0;
         for (int i = 0; i < N; i++) if (i == m_owner) begin o = wb_req[i]; eg[i] = 1'b1; end
         ostb = (m_owner >= 0) && o.stb;
         tmo  = ostb && !wb_p.ack && (m_age == TMO - 1);
         chk("busy", 32'(busy), 32'(m_owner >= 0));
         chk("grant", 32'(grant), 32'(eg));
         chk("timeout_stb", 32'(timeout_stb), 32'(m_tmo));
         chk("c_stb", 32'(wb_c.stb), 32'(ostb && !tmo));
         if (m_owner >= 0) begin
            chk("c_we", 32'(wb_c.we), 32'(o.we));
            chk("c_adr", 32'(wb_c.adr), 32'(o.adr));
            chk("c_dat", 32'(wb_c.dat), 32'(o.dat));
         end
         for (int i = 0; i < N; i++) begin
            rack = (i == m_owner) && (wb_p.ack || tmo);
            chk("rsp_ack", 32'(wb_rsp[i].ack), 32'(rack));
            chk("rsp_dat", 32'(wb_rsp[i].dat),
                rack ? (wb_p.ack ? 32'(wb_p.dat) : 32'h0000_00EE) : 32'h0);
         end
         n_tmo <= tmo;
         if (m_owner >= 0) begin
            if (wb_p.ack || tmo || !ostb) begin
               n_owner <= -1;
               n_ptr   <= (m_owner + 1) % N;
            end else begin
               n_owner <= m_owner;
               n_ptr   <= m_ptr;
            end
            n_age <= m_age + 1;
         end else begin
            best = -1; bd = N;
            for (int i = 0; i < N; i++) begin
               d = (i - m_ptr + N) % N;
               if (wb_req[i].stb && d < bd) begin best = i; bd = d; end
            end
            n_owner <= best;
            n_ptr   <= m_ptr;
            n_age   <= 0;
         end
      end
   end

   // Commit the model state on the clock; reset clears it asynchronously.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1; m_ptr <= 0; m_age <= 0; m_tmo <= 1'b0;
      end else begin
         m_owner <= n_owner; m_ptr <= n_ptr; m_age <= n_age; m_tmo <= n_tmo;
      end
   end

   task automatic clear_logs();
      ack_idx.delete(); ack_cyc.delete(); stb_cyc.delete();
      ack_wdat.delete(); ack_rdat.delete(); ack_cstb.delete();
   endtask

   task automatic set_req(input int idx, input logic we, input logic [3:0] adr,
                          input logic [7:0] dat, input int n);
      for (int k = 0; k < N; k++) if (k == idx) begin
         wb_req[k].stb = 1'b1; wb_req[k].we = we;
         wb_req[k].adr = adr;  wb_req[k].dat = dat;
         rem[k] = n;
      end
   endtask

   // One cycle: log acks and strobe rises mid-cycle, then let controllers react.
   task automatic step();
      logic [N-1:0] acks;
      acks = '0;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (wb_rsp[i].ack) begin
         acks[i] = 1'b1;
         ack_idx.push_back(i); ack_cyc.push_back(cyc);
         ack_wdat.push_back(wb_c.dat); ack_rdat.push_back(wb_rsp[i].dat);
         ack_cstb.push_back(wb_c.stb);
      end
      if (wb_c.stb && !prev_stb) stb_cyc.push_back(cyc);
      prev_stb = wb_c.stb;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (acks[i] && rem[i] > 0) begin
         rem[i]--;
         if (rem[i] == 0) wb_req[i].stb = 1'b0;
      end
   endtask

   task automatic run_until(input int target, input int budget, input string nm);
      int b;
      b = 0;
      while (ack_idx.size() < target && b < budget) begin step(); b++; end
      chk(nm, 32'(ack_idx.size()), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t_req;
      wb_req = '0;
      for (int i = 0; i < N; i++) rem[i] = 0;

      // Picker at N=3 (non power of two wrap).
      pk_req = 3'b101; pk_ptr = 2'd1; #1; chk("pick_a", 32'(pk_idx), 32'd2);
      pk_req = 3'b001; pk_ptr = 2'd2; #1; chk("pick_wrap", 32'(pk_idx), 32'd0);
      pk_req = 3'b110; pk_ptr = 2'd0; #1; chk("pick_b", 32'(pk_idx), 32'd1);
      pk_req = 3'b011; pk_ptr = 2'd2; #1; chk("pick_c", 32'(pk_idx), 32'd0);
      pk_req = 3'b000; pk_ptr = 2'd1; #1; chk("pick_none", 32'(pk_valid), 32'd0);

      // Reset state.
      repeat (2) @(posedge clk); #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tmo", 32'(timeout_stb), 32'd0);
      chk("rst_cstb", 32'(wb_c.stb), 32'd0);
      chk("rst_ack", 32'({wb_rsp[1].ack, wb_rsp[0].ack}), 32'd0);
      rst_n = 1'b1;
      step();

      // Contention: both request together, req0 first, writes in order.
      clear_logs(); ack_delay = 2;
      set_req(0, 1'b1, 4'h1, 8'hA1, 1);
      set_req(1, 1'b1, 4'h2, 8'hB2, 1);
      run_until(2, 40, "cont_done");
      chk("cont_first", 32'(ack_idx[0]), 32'd0);
      chk("cont_second", 32'(ack_idx[1]), 32'd1);
      chk("cont_wdat0", 32'(ack_wdat[0]), 32'hA1);
      chk("cont_wdat1", 32'(ack_wdat[1]), 32'hB2);
      chk("cont_gap", 32'(stb_cyc[1] - ack_cyc[0]), 32'd2);

      // Round-robin: both hold for three transactions each.
      repeat (2) step();
      clear_logs(); ack_delay = 1;
      set_req(0, 1'b0, 4'h4, 8'h00, 3);
      set_req(1, 1'b0, 4'h5, 8'h00, 3);
      run_until(6, 80, "rr_done");
      for (int k = 0; k < 6; k++) chk("rr_seq", 32'(ack_idx[k]), 32'(k % 2));

      // Single read.
      repeat (2) step();
      clear_logs(); ack_delay = 2; peri_dat = 8'h5A;
      t_req = cyc;
      set_req(0, 1'b0, 4'h3, 8'h00, 1);
      run_until(1, 20, "single_done");
      chk("single_lat", 32'(stb_cyc[0] - t_req), 32'd1);
      chk("single_ackgap", 32'(ack_cyc[0] - stb_cyc[0]), 32'd2);
      chk("single_rdat", 32'(ack_rdat[0]), 32'h5A);
      chk("single_idle", 32'(busy), 32'd0);

      // Ack while idle is not forwarded.
      clear_logs(); force_ack = 1'b1;
      step(); step();
      force_ack = 1'b0;
      chk("idle_ack", 32'(ack_idx.size()), 32'd0);

      // Timeout: peripheral silent; pointer now at 1 so req1 goes first.
      clear_logs(); ack_delay = -1; peri_dat = 8'h77;
      set_req(0, 1'b0, 4'h6, 8'h00, 1);
      set_req(1, 1'b0, 4'h7, 8'h00, 1);
      run_until(1, 30, "tmo_fire");
      chk("tmo_idx", 32'(ack_idx[0]), 32'd1);
      chk("tmo_cycle", 32'(ack_cyc[0] - stb_cyc[0]), 32'(TMO - 1));
      chk("tmo_rdat", 32'(ack_rdat[0]), 32'hEE);
      chk("tmo_cstb", 32'(ack_cstb[0]), 32'd0);
      chk("tmo_pulse", 32'(timeout_stb), 32'd1);
      ack_delay = 1;
      run_until(2, 20, "tmo_next");
      chk("tmo_next_idx", 32'(ack_idx[1]), 32'd0);
      chk("tmo_next_rdat", 32'(ack_rdat[1]), 32'h77);

      // Ack on the last counted cycle: real data wins, no timeout pulse.
      repeat (2) step();
      clear_logs(); ack_delay = TMO - 1; peri_dat = 8'hC3;
      set_req(0, 1'b0, 4'h8, 8'h00, 1);
      run_until(1, 30, "race_done");
      chk("race_cycle", 32'(ack_cyc[0] - stb_cyc[0]), 32'(TMO - 1));
      chk("race_rdat", 32'(ack_rdat[0]), 32'hC3);
      chk("race_no_tmo", 32'(timeout_stb), 32'd0);

      // Reset while req1 owns the port.
      repeat (2) step();
      clear_logs(); ack_delay = -1;
      set_req(1, 1'b0, 4'h9, 8'h00, 1);
      step(); step();
      chk("mid_grant", 32'(grant), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cstb", 32'(wb_c.stb), 32'd0);
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      wb_req = '0;
      for (int i = 0; i < N; i++) rem[i] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      clear_logs(); ack_delay = 0;
      set_req(0, 1'b0, 4'hA, 8'h00, 1);
      set_req(1, 1'b0, 4'hB, 8'h00, 1);
      run_until(2, 20, "post_rst_done");
      chk("post_rst_first", 32'(ack_idx[0]), 32'd0);
      chk("post_rst_second", 32'(ack_idx[1]), 32'd1);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
